uart_tx_arbiter: RTL and testbench

Shares the single board UART transmit path (115200 baud, toward the host/`uartdpi` side) among N on-chip byte streams. Requesters present byte-wide valid/ready streams with a `last` marker. The arbiter grants one requester at a time in round-robin order and holds the grant until that message ends, so messages never interleave. It sits between the SoC's debug/printf sources and the UART transmitter, which consumes `out_*`.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmit byte
// stream among N requesters. A grant is held until the granted requester's
// message ends (req_last) or MAX_BURST beats have passed, so messages never
// interleave on the UART.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_data/req_last    N requester streams (lane i at [i*DW +: DW])
//   req_ready                      per-requester accept
//   out_valid/out_data/out_last    forwarded stream toward the UART transmitter
//   out_ready                      transmitter accept
//   out_src                        index of the granted requester
//   busy                           a grant is held

// Per-lane slice: gates one requester onto the shared output when selected.
// Unselected lanes contribute zeros so the top can OR-reduce all lanes.
module uart_tx_arbiter_lane #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic          valid,
  input  logic          last,
  input  logic [DW-1:0] data,
  input  logic          out_ready,
  output logic          ready,
  output logic          m_valid,
  output logic          m_last,
  output logic [DW-1:0] m_data
);
  assign ready   = sel & out_ready;
  assign m_valid = sel & valid;
  assign m_last  = sel & last;
  assign m_data  = sel ? data : '0;
endmodule

module uart_tx_arbiter #(
  parameter  int N         = 4,
  parameter  int DW        = 8,
  parameter  int MAX_BURST = 64,
  localparam int SW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [SW-1:0]   out_src,
  output logic            busy
);
  localparam bit         BURST_EN   = (MAX_BURST > 0);
  localparam logic [7:0] BURST_LAST = (MAX_BURST > 0) ? 8'(MAX_BURST - 1) : 8'd0;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [SW-1:0] grant, grant_n, ptr, ptr_n, pick;
  logic [7:0]    cnt, cnt_n;
  logic          found, hs, burst_end, lane_last;
  logic [N-1:0]  gsel, m_valid, m_last;
  logic [N-1:0][DW-1:0] m_data;

  // One-hot lane select, empty while idle so nothing leaks out.
  always_comb begin
    gsel = '0;
    if (state == GRANT) gsel[grant] = 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    uart_tx_arbiter_lane #(.DW(DW)) u_lane (
      .sel       (gsel[i]),
      .valid     (req_valid[i]),
      .last      (req_last[i]),
      .data      (req_data[i*DW +: DW]),
      .out_ready (out_ready),
      .ready     (req_ready[i]),
      .m_valid   (m_valid[i]),
      .m_last    (m_last[i]),
      .m_data    (m_data[i])
    );
  end

  always_comb begin
    out_valid = 1'b0;
    lane_last = 1'b0;
    out_data  = '0;
    for (int i = 0; i < N; i++) begin
      out_valid = out_valid | m_valid[i];
      lane_last = lane_last | m_last[i];
      out_data  = out_data  | m_data[i];
    end
  end

  assign burst_end = BURST_EN && (cnt == BURST_LAST);
  assign out_last  = lane_last | ((state == GRANT) & burst_end);
  assign hs        = out_valid & out_ready;
  assign out_src   = grant;
  assign busy      = (state == GRANT);

  // First valid requester scanning ptr, ptr+1, ... modulo N.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (int'(ptr) + k) % N;
      if (!found && req_valid[c]) begin
        found = 1'b1;
        pick  = SW'(c);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: if (found) begin
        state_n = GRANT;
        grant_n = pick;
        cnt_n   = '0;
      end
      GRANT: if (hs) begin
        cnt_n = cnt + 8'd1;
        if (out_last) begin
          state_n = IDLE;
          ptr_n   = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (N=4, DW=8, MAX_BURST=4): a directed vector
// table, hand-written corner sequences and a randomized run, all checked
// against an ownership-based reference model plus per-source stream scoreboard.
module tb_uart_tx_arbiter;
  localparam int N = 4, DW = 8, MB = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_last, out_ready, busy;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .out_src(out_src), .busy(busy)
  );

  typedef struct packed {
    logic rst; logic [3:0] vld; logic [31:0] data; logic [3:0] lst; logic ordy;
    logic [3:0] rdy; logic ov; logic ol; logic [7:0] od; logic [1:0] src; logic bsy;
  } vec_t;

  typedef logic [8:0] bq_t[$];
  typedef logic [7:0] dq_t[$];

  vec_t tbl[$];
  bq_t  q[N];            // pending beats per requester {last, data}
  dq_t  exp_stream[N];   // every byte ever offered per requester
  bit   gate[N];
  int   vprob = 100, rprob = 100;
  int   ordy_q[$];
  int   grants[$];
  logic [10:0] beats[$]; // {src, last, data} of each accepted output beat
  bit   prev_busy;

  // Reference model: who owns the UART, where the next scan starts,
  // how many beats the owner has sent, last reported source.
  int m_owner, m_next, m_beats, m_src;

  function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] l,
                              logic o, logic [3:0] rd, logic ov, logic ol,
                              logic [7:0] od, logic [1:0] s, logic b);
    vec_t x;
    x = '{r, v, d, l, o, rd, ov, ol, od, s, b};
    return x;
  endfunction

  function automatic logic [16:0] obs();
    return {req_ready, out_valid, out_last, out_data, out_src, busy};
  endfunction

  function automatic logic [63:0] pack_q(int qq[$]);
    logic [63:0] r;
    r = '0;
    foreach (qq[k]) if (k < 16) r[4*k +: 4] = 4'(qq[k] + 1);
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push_msg(int i, int len, int base, bit endlast = 1'b1);
    logic [8:0] b;
    for (int k = 0; k < len; k++) begin
      b = {(endlast && k == len - 1), 8'(base + k)};
      q[i].push_back(b);
      exp_stream[i].push_back(8'(base + k));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin q[i].delete(); exp_stream[i].delete(); gate[i] = 1'b0; end
    ordy_q.delete(); grants.delete(); beats.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    m_owner = -1; m_next = 0; m_beats = 0; m_src = 0; prev_busy = 1'b0;
  endtask

  // One clock: present beats, compare against the model, then retire
  // accepted beats after the edge so valid stays stable through it.
  task automatic step();
    logic [N-1:0] er, acc;
    logic eov, eol, eb;
    logic [7:0] eod;
    int c;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (!req_valid[i] && q[i].size() > 0 && !gate[i] && int'($urandom_range(99)) < vprob) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = q[i][0][7:0];
        req_last[i] = q[i][0][8];
      end
    if (ordy_q.size() > 0) out_ready = (ordy_q.pop_front() != 0);
    else out_ready = (int'($urandom_range(99)) < rprob);
    #2;
    er = '0; eov = 1'b0; eol = 1'b0; eod = '0; eb = 1'b0;
    if (m_owner >= 0) begin
      eb  = 1'b1;
      eov = req_valid[m_owner];
      eod = req_data[m_owner*DW +: DW];
      eol = req_last[m_owner] || (m_beats == MB - 1);
      er[m_owner] = out_ready;
    end
    check("cycle", obs(), {er, eov, eol, eod, 2'(m_src), eb});
    if (busy && !prev_busy) grants.push_back(int'(out_src));
    prev_busy = busy;
    if (out_valid && out_ready) beats.push_back({out_src, out_last, out_data});
    acc = req_valid & req_ready;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_next + k) % N;
        if (m_owner < 0 && req_valid[c]) begin m_owner = c; m_src = c; m_beats = 0; end
      end
    end else if (eov && out_ready) begin
      m_beats++;
      if (eol) begin m_next = (m_owner + 1) % N; m_owner = -1; end
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin void'(q[i].pop_front()); req_valid[i] = 1'b0; end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_idle(int max, string name);
    int n;
    n = 0;
    while (!(all_empty() && m_owner < 0 && req_valid == '0) && n < max) begin step(); n++; end
    if (n >= max) begin nvec++; nerr++; $display("FAIL %s: timeout after %0d cycles", name, max); end
  endtask

  initial begin
    int e[$];
    int n;
    logic [9:0] lmask;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Directed table: reset with all requesting, grant to 0, then a
    // three-byte message from requester 2.
    tbl.push_back(mk(1, 4'hF, 32'h13121110, 4'hF, 1, 4'h0, 0, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(1, 4'hF, 32'h13121110, 4'hF, 1, 4'h0, 0, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(1, 4'hF, 32'h13121110, 4'hF, 1, 4'h0, 0, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h0, 0, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 0, 4'h0, 1, 1, 8'h10, 2'd0, 1));
    tbl.push_back(mk(0, 4'hF, 32'h13121110, 4'hF, 1, 4'h1, 1, 1, 8'h10, 2'd0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h00000000, 4'h0, 1, 4'h0, 0, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(0, 4'h4, 32'h00480000, 4'h0, 1, 4'h0, 0, 0, 8'h00, 2'd0, 0));
    tbl.push_back(mk(0, 4'h4, 32'h00480000, 4'h0, 1, 4'h4, 1, 0, 8'h48, 2'd2, 1));
    tbl.push_back(mk(0, 4'h4, 32'h00690000, 4'h0, 1, 4'h4, 1, 0, 8'h69, 2'd2, 1));
    tbl.push_back(mk(0, 4'h4, 32'h000A0000, 4'h4, 1, 4'h4, 1, 1, 8'h0A, 2'd2, 1));
    tbl.push_back(mk(0, 4'h0, 32'h00000000, 4'h0, 1, 4'h0, 0, 0, 8'h00, 2'd2, 0));
    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst; req_valid = tbl[k].vld; req_data = tbl[k].data;
      req_last = tbl[k].lst; out_ready = tbl[k].ordy;
      #2;
      check($sformatf("table[%0d]", k), obs(),
            {tbl[k].rdy, tbl[k].ov, tbl[k].ol, tbl[k].od, tbl[k].src, tbl[k].bsy});
    end

    // Round-robin: 0,1,3 together, 0 has a second message queued behind.
    do_reset();
    vprob = 100; rprob = 100;
    push_msg(0, 2, 'h00); push_msg(1, 2, 'h10); push_msg(3, 2, 'h30); push_msg(0, 2, 'h40);
    run_until_idle(60, "rr_drain");
    e = {0, 1, 3, 0};
    check("rr_order", pack_q(grants), pack_q(e));

    // Lock: requester 1 stalls mid-message while 0 waits.
    do_reset();
    push_msg(1, 3, 'h20);
    step(); step();
    gate[1] = 1'b1;
    push_msg(0, 2, 'h50);
    repeat (5) begin
      step();
      check("lock_ready0", 64'(req_ready[0]), 64'd0);
      check("lock_owner", {busy, out_src}, {1'b1, 2'd1});
    end
    gate[1] = 1'b0;
    run_until_idle(40, "lock_drain");
    e = {1, 0};
    check("lock_order", pack_q(grants), pack_q(e));

    // Forced release after MAX_BURST beats, message never ends.
    do_reset();
    push_msg(0, 10, 'h60, 1'b0);
    n = 0;
    while (q[0].size() > 0 && n < 60) begin step(); n++; end
    if (n >= 60) begin nvec++; nerr++; $display("FAIL burst_drain: timeout after 60 cycles"); end
    e = {0, 0, 0};
    check("burst_grants", pack_q(grants), pack_q(e));
    check("burst_count", 64'(beats.size()), 64'd10);
    lmask = '0;
    foreach (beats[k]) if (k < 10) begin
      lmask[k] = beats[k][8];
      check("burst_data", 64'(beats[k][7:0]), 64'(8'('h60 + k)));
    end
    check("burst_last", 64'(lmask), 64'h088);
    check("burst_hold", {busy, out_src}, {1'b1, 2'd0});

    // Backpressure: no beat lost or duplicated.
    do_reset();
    push_msg(2, 3, 'h70);
    ordy_q = {1, 1, 0, 0, 1, 1};
    run_until_idle(30, "bp_drain");
    check("bp_count", 64'(beats.size()), 64'd3);
    foreach (beats[k]) if (k < 3)
      check("bp_beat", 64'(beats[k]), 64'({2'd2, (k == 2), 8'('h70 + k)}));

    // Reset mid-message aborts and restarts the scan at requester 0.
    push_msg(3, 3, 'h80);
    step(); step();
    check("abort_busy_before", 64'(busy), 64'd1);
    do_reset();
    check("abort_idle", {busy, out_valid, req_ready}, 6'd0);
    push_msg(1, 1, 'h90); push_msg(3, 1, 'hA0);
    run_until_idle(30, "abort_drain");
    e = {1, 3};
    check("abort_order", pack_q(grants), pack_q(e));

    // Randomized traffic against the model and per-source scoreboard.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 100 == 0) begin vprob = $urandom_range(30, 100); rprob = $urandom_range(20, 100); end
      for (int i = 0; i < N; i++)
        if (q[i].size() < 3 && $urandom_range(9) == 0)
          push_msg(i, $urandom_range(1, 7), $urandom_range(255));
      step();
    end
    vprob = 100; rprob = 100;
    run_until_idle(500, "rand_drain");
    for (int i = 0; i < N; i++) begin
      int got, bad;
      got = 0; bad = 0;
      foreach (beats[k]) if (int'(beats[k][10:9]) == i) begin
        if (got >= exp_stream[i].size() || beats[k][7:0] !== exp_stream[i][got]) bad++;
        got++;
      end
      check($sformatf("stream[%0d]", i), {32'(got), 32'(bad)}, {32'(exp_stream[i].size()), 32'd0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
